// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: load width/sign encodings.
package stage_mem_pkg;

  typedef enum logic [2:0] {
    LOAD_W  = 3'b000,
    LOAD_B  = 3'b001,
    LOAD_H  = 3'b010,
    LOAD_BU = 3'b101,
    LOAD_HU = 3'b110
  } load_op_e;

endpackage

// File: rtl/stage_mem_load_align.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_align
  import stage_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_op,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unlisted encodings fall through to a full-word load.
  always_comb begin
    data = rdata;
    case (load_op)
      LOAD_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_BU: data = {24'h0, byte_sel};
      LOAD_H:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_HU: data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: waits for SRAM read data, aligns loads,
// holds load data across downstream stalls and exports forwarding info.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validin,
  output logic        allowin,
  input  logic        allowout,
  output logic        validout,
  input  logic [31:0] input_pc,
  output logic [31:0] output_pc,
  input  logic [4:0]  input_rf_waddr,
  output logic [4:0]  output_rf_waddr,
  input  logic        input_rf_we,
  output logic        output_rf_we,
  input  logic        input_mem_read,
  input  logic [2:0]  input_load_op,
  input  logic [31:0] input_alu_result,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] output_rf_wdata,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
  output logic        fwd_pending
);

  localparam int unsigned CW = (MEM_WAIT == 0) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_C = CW'(MEM_WAIT);

  logic          valid;
  logic [31:0]   pc_q;
  logic [4:0]    waddr_q;
  logic          rf_we_q;
  logic          mem_read_q;
  logic [2:0]    load_op_q;
  logic [31:0]   alu_q;
  logic [CW-1:0] cnt;
  logic          held;
  logic [31:0]   rdata_q;
  logic          readygo;
  logic          capture;
  logic          is_load;
  logic [31:0]   eff_rdata;
  logic [31:0]   load_data;

  assign is_load  = valid && mem_read_q;
  assign readygo  = !is_load || (cnt == WAIT_C);
  assign allowin  = !valid || (readygo && allowout);
  assign validout = valid && readygo;
  assign capture  = allowin && validin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid      <= 1'b0;
      pc_q       <= '0;
      waddr_q    <= '0;
      rf_we_q    <= 1'b0;
      mem_read_q <= 1'b0;
      load_op_q  <= '0;
      alu_q      <= '0;
      cnt        <= '0;
      held       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (allowin) valid <= validin;
      if (capture) begin
        pc_q       <= input_pc;
        waddr_q    <= input_rf_waddr;
        rf_we_q    <= input_rf_we;
        mem_read_q <= input_mem_read;
        load_op_q  <= input_load_op;
        alu_q      <= input_alu_result;
        cnt        <= '0;
        held       <= 1'b0;
      end else begin
        if (is_load && cnt < WAIT_C) cnt <= cnt + 1'b1;
        // SRAM data is only valid on the sampling cycle; keep it for stalls.
        if (is_load && cnt == WAIT_C && !held) begin
          rdata_q <= data_sram_rdata;
          held    <= 1'b1;
        end
      end
    end
  end

  assign eff_rdata = held ? rdata_q : data_sram_rdata;

  load_align u_align (
    .rdata   (eff_rdata),
    .addr    (alu_q[1:0]),
    .load_op (load_op_q),
    .data    (load_data)
  );

  assign output_pc       = pc_q;
  assign output_rf_waddr = waddr_q;
  assign output_rf_we    = rf_we_q;
  assign output_rf_wdata = mem_read_q ? load_data : alu_q;
  assign fwd_we          = valid && rf_we_q && (waddr_q != '0);
  assign fwd_waddr       = waddr_q;
  assign fwd_wdata       = output_rf_wdata;
  assign fwd_pending     = is_load && !readygo;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem with MEM_WAIT=0 and MEM_WAIT=2 instances.
module tb_stage_mem;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validin = 1'b0;
  logic        allowout = 1'b1;
  logic [31:0] pc_in = '0;
  logic [4:0]  waddr_in = '0;
  logic        we_in = 1'b0;
  logic        mr_in = 1'b0;
  logic [2:0]  op_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] rdata = '0;

  logic        o0_allowin, o0_validout, o0_we, o0_fwd_we, o0_pending;
  logic [31:0] o0_pc, o0_wdata, o0_fwd_wdata;
  logic [4:0]  o0_waddr, o0_fwd_waddr;
  logic        o2_allowin, o2_validout, o2_we, o2_fwd_we, o2_pending;
  logic [31:0] o2_pc, o2_wdata, o2_fwd_wdata;
  logic [4:0]  o2_waddr, o2_fwd_waddr;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  stage_mem #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .validin(validin), .allowin(o0_allowin),
    .allowout(allowout), .validout(o0_validout), .input_pc(pc_in),
    .output_pc(o0_pc), .input_rf_waddr(waddr_in), .output_rf_waddr(o0_waddr),
    .input_rf_we(we_in), .output_rf_we(o0_we), .input_mem_read(mr_in),
    .input_load_op(op_in), .input_alu_result(alu_in), .data_sram_rdata(rdata),
    .output_rf_wdata(o0_wdata), .fwd_we(o0_fwd_we), .fwd_waddr(o0_fwd_waddr),
    .fwd_wdata(o0_fwd_wdata), .fwd_pending(o0_pending)
  );

  stage_mem #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .validin(validin), .allowin(o2_allowin),
    .allowout(allowout), .validout(o2_validout), .input_pc(pc_in),
    .output_pc(o2_pc), .input_rf_waddr(waddr_in), .output_rf_waddr(o2_waddr),
    .input_rf_we(we_in), .output_rf_we(o2_we), .input_mem_read(mr_in),
    .input_load_op(op_in), .input_alu_result(alu_in), .data_sram_rdata(rdata),
    .output_rf_wdata(o2_wdata), .fwd_we(o2_fwd_we), .fwd_waddr(o2_fwd_waddr),
    .fwd_wdata(o2_fwd_wdata), .fwd_pending(o2_pending)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] a,
                                           input logic [2:0] op);
    logic [31:0] b, h;
    b = d >> (8 * a);
    h = a[1] ? (d >> 16) : d;
    case (op)
      3'b001:  return {{24{b[7]}}, b[7:0]};
      3'b101:  return {24'h0, b[7:0]};
      3'b010:  return {{16{h[15]}}, h[15:0]};
      3'b110:  return {16'h0, h[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [4:0] wa, input logic we,
                       input logic mr, input logic [2:0] op, input logic [31:0] alu,
                       input logic [31:0] exp_wdata);
    validin = 1'b1; pc_in = pc; waddr_in = wa; we_in = we;
    mr_in = mr; op_in = op; alu_in = alu;
    sb.push_back('{pc: pc, waddr: wa, we: we, wdata: exp_wdata});
  endtask

  task automatic do_reset;
    @(negedge clk);
    validin = 1'b0; allowout = 1'b1; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({o0_validout, o0_allowin, o0_fwd_we, o0_pending} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_ctl0 got %b want 0100", {o0_validout, o0_allowin, o0_fwd_we, o0_pending});
    end
    n_cmp++;
    if ({o0_pc, o0_we, o0_wdata} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_data0 got pc=%h we=%b wd=%h want zeros", o0_pc, o0_we, o0_wdata);
    end
    n_cmp++;
    if ({o2_validout, o2_allowin, o2_fwd_we, o2_pending, o2_pc, o2_we, o2_wdata} !== {4'b0100, 65'h0}) begin
      n_fail++;
      $display("FAIL reset_2 got vo=%b ai=%b fw=%b fp=%b pc=%h wd=%h", o2_validout, o2_allowin,
               o2_fwd_we, o2_pending, o2_pc, o2_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_pass_through;
    do_reset();
    drive(32'h0000_1000, 5'd5, 1'b1, 1'b0, 3'b000, 32'h1234_5678, 32'h1234_5678);
    @(negedge clk);
    validin = 1'b0;
    n_cmp++;
    if ({o0_validout, o0_fwd_we, o0_fwd_waddr, o0_fwd_wdata} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL pass_fwd got vo=%b fwe=%b fwa=%0d fwd=%h want 1 1 5 12345678",
               o0_validout, o0_fwd_we, o0_fwd_waddr, o0_fwd_wdata);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({o0_pc, o0_waddr, o0_we, o0_wdata} !== e) begin
      n_fail++;
      $display("FAIL pass_out got %h want %h", {o0_pc, o0_waddr, o0_we, o0_wdata}, e);
    end
    @(negedge clk);
    n_cmp++;
    if (o0_validout !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_drain got validout=%b want 0", o0_validout);
    end
  endtask

  task automatic test_loads;
    logic [31:0] t_rd[8]  = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'hBEEF_1234,
                              32'hBEEF_1234, 32'hBEEF_1234, 32'hCAFE_F00D, 32'hCAFE_F00D};
    logic [1:0]  t_ad[8]  = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [2:0]  t_op[8]  = '{3'b001, 3'b101, 3'b001, 3'b010, 3'b110, 3'b010, 3'b000, 3'b111};
    logic [31:0] t_exp[8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'hFFFF_BEEF,
                              32'h0000_BEEF, 32'h0000_1234, 32'h0, 32'h0};
    t_exp[6] = ref_load(t_rd[6], t_ad[6], t_op[6]);
    t_exp[7] = ref_load(t_rd[7], t_ad[7], t_op[7]);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rdata = t_rd[i];
      drive(32'h2000 + 32'(i), 5'd7, 1'b1, 1'b1, t_op[i], {30'h0400_0000, t_ad[i]}, t_exp[i]);
      @(negedge clk);
      validin = 1'b0;
      e = sb.pop_front();
      n_cmp++;
      if (o0_validout !== 1'b1 || {o0_pc, o0_waddr, o0_we, o0_wdata} !== e) begin
        n_fail++;
        $display("FAIL load_%0d got vo=%b wd=%h pc=%h want wd=%h pc=%h", i, o0_validout,
                 o0_wdata, o0_pc, e.wdata, e.pc);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (o0_validout !== 1'b1 || o0_allowin !== 1'b1 || {o0_pc, o0_waddr, o0_we, o0_wdata} !== e) begin
          n_fail++;
          $display("FAIL b2b_%0d got vo=%b ai=%b out=%h want %h", i, o0_validout, o0_allowin,
                   {o0_pc, o0_waddr, o0_we, o0_wdata}, e);
        end
      end
      if (i < 6) drive(32'h3000 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 3'b000,
                       32'hA5A5_0000 ^ 32'(i * 32'h1111), 32'hA5A5_0000 ^ 32'(i * 32'h1111));
      else validin = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_wait;
    int unsigned waited;
    do_reset();
    rdata = 32'hBEEF_1234;
    drive(32'h4000, 5'd9, 1'b1, 1'b1, 3'b010, 32'h0000_0102, 32'hFFFF_BEEF);
    @(negedge clk);
    validin = 1'b0;
    waited = 0;
    while (o2_validout !== 1'b1 && waited < 10) begin
      n_cmp++;
      if ({o2_pending, o2_allowin} !== 2'b10) begin
        n_fail++;
        $display("FAIL wait_pending_%0d got fp=%b ai=%b want 1 0", waited, o2_pending, o2_allowin);
      end
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (waited != 2) begin
      n_fail++;
      $display("FAIL wait_cycles got %0d want 2", waited);
    end
    e = sb.pop_front();
    n_cmp++;
    if (o2_pending !== 1'b0 || {o2_pc, o2_waddr, o2_we, o2_wdata} !== e) begin
      n_fail++;
      $display("FAIL wait_out got fp=%b wd=%h want 0 %h", o2_pending, o2_wdata, e.wdata);
    end
  endtask

  task automatic test_stall;
    do_reset();
    allowout = 1'b0;
    rdata = 32'h1111_1111;
    drive(32'h5000, 5'd3, 1'b1, 1'b1, 3'b000, 32'h0000_0200, 32'h1111_1111);
    @(negedge clk);
    validin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({o0_validout, o0_allowin} !== 2'b10 || o0_wdata !== 32'h1111_1111) begin
        n_fail++;
        $display("FAIL stall_%0d got vo=%b ai=%b wd=%h want 1 0 11111111", k, o0_validout,
                 o0_allowin, o0_wdata);
      end
      if (k > 0) rdata = (k % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111;
      @(negedge clk);
    end
    allowout = 1'b1;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (o0_allowin !== 1'b1 || {o0_pc, o0_waddr, o0_we, o0_wdata} !== e) begin
      n_fail++;
      $display("FAIL stall_release got ai=%b wd=%h want 1 %h", o0_allowin, o0_wdata, e.wdata);
    end
    @(negedge clk);
    n_cmp++;
    if (o0_validout !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain got validout=%b want 0", o0_validout);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    drive(32'h6000, 5'd4, 1'b1, 1'b1, 3'b000, 32'h0000_0300, 32'h0);
    @(negedge clk);
    validin = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o2_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL midwait_pre got fp=%b want 1", o2_pending);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({o2_validout, o2_allowin, o2_pending, o2_pc} !== {3'b010, 32'h0}) begin
      n_fail++;
      $display("FAIL midwait_async got vo=%b ai=%b fp=%b pc=%h want 0 1 0 0", o2_validout,
               o2_allowin, o2_pending, o2_pc);
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    drive(32'h6100, 5'd12, 1'b1, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clk);
    validin = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (o2_validout !== 1'b1 || {o2_pc, o2_waddr, o2_we, o2_wdata} !== e) begin
      n_fail++;
      $display("FAIL midwait_after got vo=%b out=%h want 1 %h", o2_validout,
               {o2_pc, o2_waddr, o2_we, o2_wdata}, e);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_loads();
    test_back_to_back();
    test_wait();
    test_stall();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
